// File: rtl/ram_loader.sv
// Byte-stream loader for the 16x8 RAM: writes DEPTH bytes in address order, optionally
// reads them back and compares checksums, and holds the CPU halted while it owns the bus.
module ram_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              ri,
  output logic              ro,
  inout  wire  [DATA_W-1:0] data,
  output logic              busy,
  output logic              cpu_halt,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_VERIFY, S_CHECK, S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] load_sum_q, load_sum_d;
  logic [DATA_W-1:0] verify_sum_q, verify_sum_d;
  logic              error_q, error_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      hold_q       <= '0;
      load_sum_q   <= '0;
      verify_sum_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      load_sum_q   <= load_sum_d;
      verify_sum_q <= verify_sum_d;
      error_q      <= error_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hold_d       = hold_q;
    load_sum_d   = load_sum_q;
    verify_sum_d = verify_sum_q;
    error_d      = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          addr_d       = '0;
          load_sum_d   = '0;
          verify_sum_d = '0;
          error_d      = 1'b0;
        end
      end
      S_LOAD: begin
        // in_ready is high for the whole of LOAD, so in_valid alone completes the handshake
        if (in_valid) begin
          hold_d  = in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        load_sum_d = load_sum_q + hold_q;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = (VERIFY != 0) ? S_VERIFY : S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_VERIFY: begin
        verify_sum_d = verify_sum_q + data;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_CHECK;
        end else begin
          addr_d  = addr_q + 1'b1;
        end
      end
      S_CHECK: begin
        error_d = (load_sum_q != verify_sum_q);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state and address, never on start or in_valid.
  always_comb begin
    in_ready    = (state_q == S_LOAD);
    ri          = (state_q == S_WRITE);
    ro          = (state_q == S_VERIFY);
    busy        = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                  (state_q == S_VERIFY) || (state_q == S_CHECK);
    cpu_halt    = busy;
    done        = (state_q == S_DONE);
    error       = error_q;
    mem_address = addr_q;
  end

  assign data = ri ? hold_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a per-cycle schedule built from the handshake
// rules predicts every output, and bench RAM models hold what was written.
module tb_ram_loader;
  localparam int N    = 16;
  localparam int MAXC = 200;

  logic clk = 1'b0;
  logic rst, start_a, start_b, in_valid;
  logic [7:0] in_data;

  logic       rdy_a, ri_a, ro_a, busy_a, halt_a, done_a, err_a;
  logic       rdy_b, ri_b, ro_b, busy_b, halt_b, done_b, err_b;
  logic [3:0] addr_a, addr_b;
  wire  [7:0] data_a, data_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8), .VERIFY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .mem_address(addr_a), .ri(ri_a), .ro(ro_a), .data(data_a),
    .busy(busy_a), .cpu_halt(halt_a), .done(done_a), .error(err_a)
  );

  ram_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8), .VERIFY(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .mem_address(addr_b), .ri(ri_b), .ro(ro_b), .data(data_b),
    .busy(busy_b), .cpu_halt(halt_b), .done(done_b), .error(err_b)
  );

  // An undriven bus floats high, so a released bus reads 0xFF.
  pullup (data_a);
  pullup (data_b);

  // Bench RAMs; location 5 of RAM A can read back with bit0 stuck at 0.
  logic [7:0] ram_a [N];
  logic [7:0] ram_b [N];
  logic [7:0] rd_a;
  bit         stuck5 = 1'b0;

  always @(posedge clk) begin
    if (ri_a) ram_a[addr_a] <= data_a;
    if (ri_b) ram_b[addr_b] <= data_b;
  end
  always_comb rd_a = ram_a[addr_a] & ((stuck5 && addr_a == 4'd5) ? 8'hFE : 8'hFF);
  assign data_a = ro_a ? rd_a : 8'hzz;
  assign data_b = ro_b ? ram_b[addr_b] : 8'hzz;

  // Observation mux: the run under test is on DUT A when sel_a=1, DUT B otherwise.
  bit          sel_a = 1'b1;
  logic [10:0] obs_a, obs_b, obs;
  logic [7:0]  obs_data;
  assign obs_a    = {ri_a, ro_a, rdy_a, busy_a, halt_a, done_a, err_a, addr_a};
  assign obs_b    = {ri_b, ro_b, rdy_b, busy_b, halt_b, done_b, err_b, addr_b};
  assign obs      = sel_a ? obs_a : obs_b;
  assign obs_data = sel_a ? data_a : data_b;

  // Expected schedule, indexed by cycle c = the cycle following rising edge c.
  logic [7:0] bq   [N];
  bit         pat  [MAXC];
  logic [7:0] din  [MAXC];
  bit         e_ri [MAXC], e_ro [MAXC], e_rdy [MAXC], e_busy [MAXC], e_done [MAXC];
  logic [3:0] e_addr [MAXC];
  logic [7:0] e_wdata [MAXC];
  int         done_c;

  // mode 0: in_valid always 1; mode 1: 1,0,0 repeating; mode 2: random.
  task automatic build_sched(input bit v, input int mode);
    int t;
    for (int e = 0; e < MAXC; e++) begin
      case (mode)
        0:       pat[e] = 1'b1;
        1:       pat[e] = (e % 3 == 1);
        default: pat[e] = (e >= 80) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      din[e] = 8'($urandom);
      {e_ri[e], e_ro[e], e_rdy[e], e_busy[e], e_done[e]} = '0;
      e_addr[e] = '0;
      e_wdata[e] = '0;
    end
    t = 1;
    for (int k = 0; k < N; k++) begin
      while (!pat[t]) begin
        e_rdy[t-1] = 1'b1; e_addr[t-1] = 4'(k); t++;
      end
      e_rdy[t-1] = 1'b1; e_addr[t-1] = 4'(k);
      din[t]     = bq[k];
      e_ri[t]    = 1'b1; e_addr[t] = 4'(k); e_wdata[t] = bq[k];
      t += 2;
    end
    if (v) begin
      for (int i = 0; i < N; i++) begin
        e_ro[t-1+i] = 1'b1; e_addr[t-1+i] = 4'(i);
      end
      done_c = t - 1 + N + 1;
    end else begin
      done_c = t - 1;
    end
    for (int c = 0; c < done_c; c++) e_busy[c] = 1'b1;
    e_done[done_c] = 1'b1;
  endtask

  task automatic drive_run(input bit use_a, input bit v, input bit stuck,
                           input int pulse_edge, input string tag);
    logic [7:0]  s_w, s_r, expd, got;
    logic [10:0] expv;
    bit          exp_err;
    s_w = '0;
    s_r = '0;
    for (int i = 0; i < N; i++) begin
      s_w += bq[i];
      s_r += bq[i] & ((stuck && i == 5) ? 8'hFE : 8'hFF);
    end
    exp_err  = v && (s_w != s_r);
    stuck5   = stuck;
    sel_a    = use_a;
    in_valid = pat[0];
    in_data  = din[0];
    if (use_a) start_a = 1'b1; else start_b = 1'b1;
    for (int c = 0; c <= done_c + 3; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      expv = {e_ri[c], e_ro[c], e_rdy[c], e_busy[c], e_busy[c], e_done[c],
              (c >= done_c) ? exp_err : 1'b0, e_addr[c]};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s ctrl cycle %0d: {ri,ro,rdy,busy,halt,done,err,addr} got %b expected %b",
                 tag, c, obs, expv);
      end
      if (e_ri[c] || !e_ro[c]) begin
        expd = e_ri[c] ? e_wdata[c] : 8'hFF;
        checks++;
        if (obs_data !== expd) begin
          errors++;
          $display("FAIL %s bus cycle %0d: got %h expected %h", tag, c, obs_data, expd);
        end
      end
      in_valid = pat[c+1];
      in_data  = din[c+1];
      if (c + 1 == pulse_edge) begin
        if (use_a) start_a = 1'b1; else start_b = 1'b1;
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      got = use_a ? ram_a[i] : ram_b[i];
      checks++;
      if (got !== bq[i]) begin
        errors++;
        $display("FAIL %s ram[%0d]: got %h expected %h", tag, i, got, bq[i]);
      end
    end
  endtask

  task automatic fill_random;
    for (int i = 0; i < N; i++) bq[i] = 8'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_a !== 11'd0 || obs_b !== 11'd0) begin
      errors++;
      $display("FAIL reset outputs: got a=%b b=%b expected all 0", obs_a, obs_b);
    end
    checks++;
    if (data_a !== 8'hFF || data_b !== 8'hFF) begin
      errors++;
      $display("FAIL reset bus: got a=%h b=%h expected released (ff)", data_a, data_b);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_incrementing;
    for (int i = 0; i < N; i++) bq[i] = 8'(i);
    build_sched(1'b1, 0);
    drive_run(1'b1, 1'b1, 1'b0, -1, "incr");
  endtask

  task automatic test_all_ff;
    for (int i = 0; i < N; i++) bq[i] = 8'hFF;
    build_sched(1'b1, 0);
    drive_run(1'b1, 1'b1, 1'b0, -1, "all_ff");
  endtask

  task automatic test_stuck_bit;
    for (int i = 0; i < N; i++) bq[i] = 8'h01;
    build_sched(1'b1, 0);
    drive_run(1'b1, 1'b1, 1'b1, -1, "stuck");
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL stuck sticky: got err=%b busy=%b expected err=1 busy=0", err_a, busy_a);
    end
  endtask

  task automatic test_toggle_valid;
    fill_random();
    build_sched(1'b1, 1);
    drive_run(1'b1, 1'b1, 1'b0, -1, "toggle");
  endtask

  task automatic test_random_start_in_verify;
    fill_random();
    build_sched(1'b1, 2);
    drive_run(1'b1, 1'b1, 1'b0, done_c - 10, "rand_pulse");
  endtask

  task automatic test_rst_mid;
    fill_random();
    build_sched(1'b1, 0);
    sel_a    = 1'b1;
    stuck5   = 1'b0;
    in_valid = pat[0];
    in_data  = din[0];
    start_a  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      start_a  = 1'b0;
      in_valid = pat[c+1];
      in_data  = din[c+1];
    end
    checks++;
    if (ri_a !== 1'b1 || addr_a !== 4'd7) begin
      errors++;
      $display("FAIL rst_mid pre: got ri=%b addr=%0d expected ri=1 addr=7", ri_a, addr_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (obs_a !== 11'd0 || data_a !== 8'hFF) begin
      errors++;
      $display("FAIL rst_mid post: got outputs %b bus %h expected 0 and ff", obs_a, data_a);
    end
    fill_random();
    build_sched(1'b1, 0);
    drive_run(1'b1, 1'b1, 1'b0, -1, "after_rst");
  endtask

  task automatic test_no_verify;
    fill_random();
    build_sched(1'b0, 0);
    drive_run(1'b0, 1'b0, 1'b0, -1, "nover");
    fill_random();
    build_sched(1'b0, 2);
    drive_run(1'b0, 1'b0, 1'b0, -1, "nover_rand");
  endtask

  initial begin
    test_reset();
    test_incrementing();
    test_all_ff();
    test_stuck_bit();
    test_toggle_valid();
    test_random_start_in_verify();
    test_rst_mid();
    test_no_verify();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Upstream programming stage for the 16x8 RAM.
- Accepts a byte stream over a valid/ready handshake and writes it to RAM addresses 0..15 in order, driving mem_address, ri and the shared data bus.
- Optionally reads all locations back and compares checksums.
- Holds the CPU halted while it owns the RAM and bus.

Parameters:
- DEPTH, 16, number of RAM locations loaded per run.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, bus and byte width.
- VERIFY, 1, 1 = run readback/checksum phase after load; 0 = skip it.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load run; sampled only in IDLE.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  DATA_W  byte to load.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_address  output  ADDR_W  RAM address.
- ri  output  1  RAM write enable; RAM captures data on the rising clk edge.
- ro  output  1  RAM output enable; RAM drives data combinationally.
- data  inout  DATA_W  shared bus; the loader drives it only while ri=1, otherwise high-Z.
- busy  output  1  run in progress.
- cpu_halt  output  1  equals busy; the CPU must not touch the bus.
- done  output  1  one-cycle pulse at end of run.
- error  output  1  checksum mismatch; sticky until next accepted start or rst.

Behaviour:
- Reset values: state=IDLE, addr=0, sums=0, in_ready=0, ri=0, ro=0, data=Z, mem_address=0, busy=0, cpu_halt=0, done=0, error=0.
- Outputs are decoded from registered state/addr only; no combinational path from in_valid or start to ri/ro/data.
- IDLE: start=1 -> LOAD; clear addr, load_sum, verify_sum and error.
- LOAD: in_ready=1. On the in_valid&in_ready edge, capture in_data into hold_reg -> WRITE. With no in_valid, stay in LOAD and keep ri=0.
- WRITE:
  - Outputs: in_ready=0, ri=1, data=hold_reg, mem_address=addr, for exactly one cycle.
  - At the edge: load_sum += hold_reg (mod 2**DATA_W).
  - If addr==DEPTH-1: addr wraps to 0; -> VERIFY if VERIFY=1, else -> DONE.
  - Otherwise: addr++ and -> LOAD.
- Throughput: one byte per 2 cycles at best.
- VERIFY:
  - Outputs: ro=1, ri=0, data=Z, mem_address=addr.
  - Each edge: verify_sum += data, addr++.
  - After sampling addr==DEPTH-1 -> CHECK.
- CHECK: error <= (load_sum != verify_sum) -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- busy=cpu_halt=1 in LOAD, WRITE, VERIFY and CHECK.
- ri and ro are never both 1.
- start while not IDLE is ignored. start held high through DONE starts a new run only once IDLE is re-entered.
- in_valid outside LOAD is ignored; the byte is not consumed because in_ready=0.
- rst mid-run: at that edge, return to IDLE with all reset values.
  - ri/ro deassert and data goes Z from the next cycle.
  - A partially written RAM is not restored.
- Timing with start sampled at edge 0, in_valid held 1, VERIFY=1:
  - Byte k accepted at edge 2k+1, written at edge 2k+2.
  - Last write at edge 32.
  - Verify samples at edges 33..48; CHECK evaluated at edge 49.
  - done high in the cycle after edge 49; back in IDLE after edge 50.
- Same timing with VERIFY=0: done high in the cycle after edge 32.

Test Plan:
- Stream 0x00..0x0F with in_valid held 1, VERIFY=1, bench RAM model:
  - RAM[i]=i.
  - ri pulses 16 times, each 1 cycle.
  - done pulses exactly 49 edges after start; load_sum=verify_sum=0x78; error=0.
- Stream 0xFF x16: sum wraps to 0xF0; error=0; ro stays 0 during LOAD/WRITE; data is Z whenever ri=0.
- Bench RAM forces bit0 of location 5 stuck at 0; load 0x01 x16:
  - error=1 after CHECK and stays 1 through IDLE.
  - The next start clears it.
- in_valid toggles 1,0,0,1,...:
  - No ri while waiting in LOAD.
  - Bytes land at consecutive addresses with no skipped or duplicated writes.
  - done is delayed by exactly the idle cycles.
- rst asserted during WRITE of byte 7:
  - Next cycle ri=0, busy=0, in_ready=0, data=Z.
  - A new start rewrites from address 0.
- start pulsed during VERIFY: no effect, run completes normally. VERIFY=0 build: done high in the cycle after edge 32, ro never asserted.
